// File: rtl/spike_pkg.sv
// Shared types and default sizing for the spike interval decoder slice.
package spike_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TMO
  } spk_state_t;

  localparam int SPK_CNT_W   = 8;
  localparam int SPK_TIMEOUT = 200;
  localparam int SPK_LOCK_N  = 3;

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for the neuron spike line; history is cleared only by reset.
module spike_edge_detect
  import spike_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic spike_in,
  output logic spike_edge
);

  logic spike_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_d <= 1'b0;
    end else begin
      spike_d <= spike_in;
    end
  end

  // A spike already high when reset releases still counts as an edge.
  assign spike_edge = spike_in & ~spike_d;

endmodule

// File: rtl/spike_interval_decoder.sv
// Measures cycles between successive spike rising edges, reports them through a
// one-entry valid/ready register, and tracks frequency lock and loss of activity.
module spike_interval_decoder
  import spike_pkg::*;
#(
  parameter int CNT_W   = SPK_CNT_W,
  parameter int TIMEOUT = SPK_TIMEOUT,
  parameter int LOCK_N  = SPK_LOCK_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             spike_in,
  output logic [CNT_W-1:0] interval,
  output logic             interval_valid,
  input  logic             interval_ready,
  output logic             locked,
  output logic             timeout,
  output logic             overrun
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] r);
    return (r >= RUN_MAX) ? RUN_MAX : r + RUN_ONE;
  endfunction

  spk_state_t       state;
  spk_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] prev;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_cap;
  logic             spike_edge;
  logic             capture;
  logic             tmo_enter;
  logic             tmo_exit;
  logic             accept;

  spike_edge_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .spike_edge (spike_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    tmo_enter  = 1'b0;
    tmo_exit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (spike_edge) begin
          cnt_next   = CNT_ONE;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (spike_edge) begin
          capture  = 1'b1;
          cnt_next = CNT_ONE;
        end else if (cnt >= TMO_CNT) begin
          tmo_enter  = 1'b1;
          state_next = TMO;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      TMO: begin
        // The silent gap is never reported; measurement simply restarts.
        if (spike_edge) begin
          cnt_next   = CNT_ONE;
          tmo_exit   = 1'b1;
          state_next = MEASURE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign run_cap = (cnt == prev) ? sat_run(run) : RUN_ONE;
  assign accept  = interval_valid & interval_ready;

  // Output register and lock tracking; lock also follows dropped captures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval       <= '0;
      interval_valid <= 1'b0;
      overrun        <= 1'b0;
      prev           <= '0;
      run            <= '0;
      locked         <= 1'b0;
      timeout        <= 1'b0;
    end else if (clear) begin
      interval       <= '0;
      interval_valid <= 1'b0;
      overrun        <= 1'b0;
      prev           <= '0;
      run            <= '0;
      locked         <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      if (capture) begin
        if (!interval_valid || interval_ready) begin
          interval       <= cnt;
          interval_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        run    <= run_cap;
        prev   <= cnt;
        locked <= (run_cap == RUN_MAX);
      end else if (accept) begin
        interval_valid <= 1'b0;
      end
      if (tmo_enter) begin
        timeout <= 1'b1;
        run     <= '0;
        locked  <= 1'b0;
      end
      if (tmo_exit) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_interval_decoder.sv
// Directed bench for spike_interval_decoder: expected intervals are queued as
// stimulus is issued and checked by a monitor whenever the output is consumed.
module tb_spike_interval_decoder;
  import spike_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       spike_in;
  logic       interval_ready;
  logic [7:0] interval;
  logic       interval_valid;
  logic       locked;
  logic       timeout;
  logic       overrun;

  typedef struct packed {
    logic [7:0] iv;
    logic       lk;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spike_interval_decoder #(
    .CNT_W   (8),
    .TIMEOUT (200),
    .LOCK_N  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .spike_in       (spike_in),
    .interval       (interval),
    .interval_valid (interval_valid),
    .interval_ready (interval_ready),
    .locked         (locked),
    .timeout        (timeout),
    .overrun        (overrun)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] iv, input logic lk);
    exp_t x;
    x.iv = iv;
    x.lk = lk;
    sb.push_back(x);
  endtask

  // Rising edge now, high for w cycles, next edge p cycles later.
  task automatic spike_period(input int p, input int w);
    spike_in = 1'b1;
    tick(w);
    spike_in = 1'b0;
    tick(p - w);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_interval"}, interval, 0);
    chk({tag, "_valid"}, interval_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (interval_valid && interval_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_interval: got %0d expected none", interval);
          end else begin
            e = sb.pop_front();
            chk("interval", interval, e.iv);
            chk("locked_with_interval", locked, e.lk);
          end
        end
      end
    join_none

    reset = 1'b1;
    clear = 1'b0;
    spike_in = 1'b0;
    interval_ready = 1'b1;
    tick(2);
    check_zero("reset");
    reset = 1'b0;
    tick(1);

    // Period-5 neuron pulses, lock on the third interval.
    push(8'd5, 1'b0);
    push(8'd5, 1'b0);
    push(8'd5, 1'b1);
    push(8'd5, 1'b1);
    repeat (5) spike_period(5, 1);
    chk("t1_overrun", overrun, 0);
    chk("t1_drain", sb.size(), 0);
    clear_pulse();
    check_zero("clear1");

    // Gaps 5,5,7,7,7.
    push(8'd5, 1'b0);
    push(8'd5, 1'b0);
    push(8'd7, 1'b0);
    push(8'd7, 1'b0);
    push(8'd7, 1'b1);
    spike_period(5, 1);
    spike_period(5, 1);
    repeat (3) spike_period(7, 1);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;

    // Silence: timeout exactly 200 updates after the last edge.
    tick(199);
    chk("t2_drain", sb.size(), 0);
    chk("t3_locked_before_tmo", locked, 1);
    chk("t3_timeout_early", timeout, 0);
    tick(1);
    chk("t3_timeout", timeout, 1);
    chk("t3_locked_cleared", locked, 0);
    tick(3);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    chk("t3_timeout_exit", timeout, 0);
    chk("t3_no_gap_interval", interval_valid, 0);
    tick(4);
    push(8'd5, 1'b0);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    tick(2);
    chk("t3_drain", sb.size(), 0);

    // Consumer stalled: hold first value, drop the second.
    clear_pulse();
    interval_ready = 1'b0;
    spike_period(5, 1);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    chk("t4_valid", interval_valid, 1);
    chk("t4_interval", interval, 5);
    chk("t4_no_overrun_yet", overrun, 0);
    tick(4);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    chk("t4_interval_stable", interval, 5);
    chk("t4_valid_held", interval_valid, 1);
    chk("t4_overrun", overrun, 1);
    tick(2);
    push(8'd5, 1'b0);
    interval_ready = 1'b1;
    tick(1);
    chk("t4_valid_drop", interval_valid, 0);
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_drain", sb.size(), 0);

    // Wide spikes: measured rising edge to rising edge.
    clear_pulse();
    chk("t5_overrun_cleared", overrun, 0);
    push(8'd10, 1'b0);
    push(8'd10, 1'b0);
    push(8'd10, 1'b1);
    repeat (4) spike_period(10, 3);
    chk("t5_drain", sb.size(), 0);

    // Asynchronous reset with an interval pending.
    clear_pulse();
    interval_ready = 1'b0;
    spike_period(5, 1);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    tick(2);
    chk("t6_pending", interval_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    interval_ready = 1'b1;
    tick(1);
    push(8'd5, 1'b0);
    spike_period(5, 1);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    tick(2);
    chk("t6_reset_drain", sb.size(), 0);

    // Clear coincident with an edge: the edge is lost.
    spike_in = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    spike_in = 1'b0;
    check_zero("clear_edge");
    tick(2);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    chk("t6_restart_only", interval_valid, 0);
    tick(4);
    push(8'd5, 1'b0);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    tick(3);
    chk("t6_final_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_interval_decoder.md
# spike_interval_decoder

Receive-side counterpart to the oscillator neuron: consumes the neuron's spike pulse train and measures the clock-cycle interval between successive spikes. Emits each interval through a one-entry valid/ready output register. Flags frequency lock after a run of identical intervals and flags loss of activity when no spike arrives within a timeout. Sits between each neuron and the network's phase/frequency monitoring logic.

## Interface
- CNT_W, 8: interval counter and output width.
- TIMEOUT, 200: cycles without a spike before timeout; legal range 2 .. 2^CNT_W-1.
- LOCK_N, 3: consecutive equal intervals required for lock; legal range ≥ 2.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous clear; behaves as reset except for edge-detector history.
- spike_in  in  1  spike from neuron, synchronous to clk; may be high for more than one cycle.
- interval  out  CNT_W  measured interval in clk cycles.
- interval_valid  out  1  interval holds an unconsumed value.
- interval_ready  in  1  consumer accepts when valid && ready.
- locked  out  1  last LOCK_N intervals equal.
- timeout  out  1  no spike for TIMEOUT cycles.
- overrun  out  1  sticky: an interval was dropped.

## Operation
- Edge detect: edge = spike_in & ~spike_d. spike_d resets to 0, so spike_in high at reset release counts as an edge. clear does not affect spike_d.
- States: IDLE, MEASURE, TMO.
- IDLE: on edge, cnt ← 1, go to MEASURE. No interval is emitted.
- MEASURE, edge: capture cnt as a new interval, cnt ← 1, stay in MEASURE.
- MEASURE, no edge, cnt < TIMEOUT: cnt ← cnt+1.
- MEASURE, no edge, cnt == TIMEOUT: go to TMO. In the same update, timeout ← 1, run ← 0, locked ← 0.
- TMO: on edge, cnt ← 1, timeout ← 0, go to MEASURE. The gap is not reported.
- cnt never exceeds TIMEOUT, so no wrap is possible. The largest reportable interval is TIMEOUT.
- Output buffer, on capture:
  - Buffer empty, or valid && ready in the same cycle: load interval, valid ← 1.
  - valid && !ready: keep the old value, discard the new one, overrun ← 1 (sticky until reset/clear).
- Output buffer, no capture: valid && ready → valid ← 0.
- Lock tracking runs on every capture, including dropped ones, and is independent of the handshake:
  - Capture equal to prev: run ← min(run+1, LOCK_N).
  - Otherwise: run ← 1.
  - Then prev ← capture.
  - locked = (run == LOCK_N).
- clear: state ← IDLE. cnt, run, prev, interval_valid, locked, timeout and overrun all ← 0. clear wins over a simultaneous edge, and that edge is lost.

## Timing
- Reset values: interval 0, interval_valid 0, locked 0, timeout 0, overrun 0; state IDLE.
- Reset is asynchronous: assertion mid-measurement clears all outputs immediately, with no pending interval retained.
- Interval latency: an edge sampled at cycle t gives interval/interval_valid at t+1. locked updates in that same cycle.
- Spikes one cycle wide every P cycles report interval P.
- Timeout latency: for an edge at cycle t with no further edges, timeout asserts at t+TIMEOUT+1.
- interval is stable while valid && !ready.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package spike_pkg holds:
  - enum spk_state_t {IDLE, MEASURE, TMO};
  - default constants SPK_CNT_W=8, SPK_TIMEOUT=200, SPK_LOCK_N=3.
- One sub-module, spike_edge_detect (clk, reset, spike_in → edge), holding spike_d.
- FSM, counter, lock tracking and output register live in spike_interval_decoder.

## Test plan
- Neuron-style spikes (1-cycle pulse every 5 cycles), ready=1 → intervals 5,5,5…; locked rises together with the 3rd reported interval; overrun=0.
- Spikes at gaps 5,5,7,7,7 → intervals 5,5,7,7,7; locked stays 0 until the third 7, then 1.
- Single spike, then silence with TIMEOUT=200 → timeout=1 exactly 201 cycles after the edge, locked=0. Next spike: timeout=0, no interval emitted. Spike 5 cycles later reports 5.
- ready=0, spikes every 5 cycles → first interval 5 held stable with valid=1, overrun=1 after the next capture. Raise ready → value 5 accepted once, valid drops to 0.
- spike_in held high for 3 cycles every 10 cycles → intervals of 10, measured rising edge to rising edge.
- Assert reset mid-measurement, and separately assert clear coincident with an edge → all outputs 0, state IDLE. The edge under clear is ignored; the next spike only restarts measurement.
